// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD byte feeder.
//   - lcdState_e   : sequencer state encoding
//   - LCD_CMD_*    : command bytes that need the long post-byte delay
//   - *_DEFAULT    : default delay / timeout cycle counts (50 MHz clock)
//   - isLongCmd()  : selects the long delay for clear/home commands
// Optional build macro used by the feeder: LCD_FEEDER_FIFO_EN (4-entry FIFO).
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND_HI = 3'd1,
        REL_HI  = 3'd2,
        SEND_LO = 3'd3,
        DELAY   = 3'd4
    } lcdState_e;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

    localparam int WAIT_SHORT_DEFAULT   = 2000;
    localparam int WAIT_LONG_DEFAULT    = 82000;
    localparam int RESP_TIMEOUT_DEFAULT = 1024;

    // Delay and timeout counters; 17 bits covers the 82000-cycle wait.
    localparam int CNT_W = 17;

    // Buffer entry layout: {rs, byte}.
    localparam int ENTRY_W = 9;

    // Clear and home are the only slow controller commands; data bytes with
    // the same value are ordinary characters.
    function automatic logic isLongCmd(input logic rs, input logic [7:0] value);
        return (rs == 1'b0) && ((value == LCD_CMD_CLEAR) || (value == LCD_CMD_HOME));
    endfunction

endpackage

// File: rtl/lcd_feeder_fifo.sv
// Generic show-ahead FIFO used as the feeder's input buffer.
// With DEPTH=1 it degenerates into a single holding register.
// Ports:
//   clk, iReset_n       : clock, synchronous active-low reset
//   push, pushData      : write one entry (ignored when full)
//   pop                 : discard head entry (ignored when empty)
//   popData             : head entry, valid whenever !empty
//   empty, full         : occupancy flags (registered count based)
module lcd_feeder_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             iReset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [0:DEPTH-1];
    logic [PTR_W-1:0] wrPtr_r;
    logic [PTR_W-1:0] rdPtr_r;
    logic [CNT_W-1:0] count_r;
    logic             doPush_s;
    logic             doPop_s;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction

    assign empty    = (count_r == {CNT_W{1'b0}});
    assign full     = (count_r == CNT_W'(DEPTH));
    assign doPush_s = push && !full;
    assign doPop_s  = pop && !empty;
    assign popData  = mem_r[rdPtr_r];

    // Storage, pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk) begin
        if (!iReset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wrPtr_r <= {PTR_W{1'b0}};
            rdPtr_r <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (doPush_s) begin
                mem_r[wrPtr_r] <= pushData;
                wrPtr_r        <= nextPtr(wrPtr_r);
            end
            if (doPop_s) begin
                rdPtr_r <= nextPtr(rdPtr_r);
            end
            case ({doPush_s, doPop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/lcd_byte_feeder.sv
// Splits upstream bytes into two 4-bit writes for an HD44780-style LCD
// controller, then waits the controller's post-byte settling time.
// Each nibble is held on oLCD_data/oLCD_RS with oLCD_writeEN high until the
// controller acknowledges on iLCD_response; a missing acknowledge aborts the
// byte and sets the sticky oError flag.
// Ports:
//   clk, iReset_n          : clock, synchronous active-low reset
//   iByte, iRS, iValid     : upstream byte offer (iRS 1 = data, 0 = command)
//   oReady                 : buffer can take a byte this cycle
//   oLCD_data, oLCD_RS     : nibble and register select to the controller
//   oLCD_writeEN           : nibble write request
//   iLCD_response          : controller nibble-done acknowledge
//   oBusy                  : a byte is in flight or buffered
//   oError                 : sticky acknowledge-timeout flag
// Build macro: LCD_FEEDER_FIFO_EN selects a 4-entry input FIFO; without it a
// single holding register is used.
module lcd_byte_feeder
    import lcd_pkg::*;
#(
    parameter int WAIT_SHORT   = WAIT_SHORT_DEFAULT,
    parameter int WAIT_LONG    = WAIT_LONG_DEFAULT,
    parameter int RESP_TIMEOUT = RESP_TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       iReset_n,
    input  logic [7:0] iByte,
    input  logic       iRS,
    input  logic       iValid,
    output logic       oReady,
    output logic [3:0] oLCD_data,
    output logic       oLCD_RS,
    output logic       oLCD_writeEN,
    input  logic       iLCD_response,
    output logic       oBusy,
    output logic       oError
);

`ifdef LCD_FEEDER_FIFO_EN
    localparam int BUF_DEPTH = 4;
`else
    localparam int BUF_DEPTH = 1;
`endif

    localparam logic [CNT_W-1:0] CNT_ZERO       = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE        = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] RESP_LAST      = CNT_W'(RESP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WAIT_SHORT_CNT = CNT_W'(WAIT_SHORT);
    localparam logic [CNT_W-1:0] WAIT_LONG_CNT  = CNT_W'(WAIT_LONG);

    lcdState_e          state_r;
    logic [7:0]         curByte_r;
    logic               curRs_r;
    logic [CNT_W-1:0]   respCnt_r;
    logic [CNT_W-1:0]   delayCnt_r;
    logic [3:0]         lcdData_r;
    logic               lcdRs_r;
    logic               lcdWriteEn_r;
    logic               error_r;

    logic [ENTRY_W-1:0] bufData_s;
    logic               bufEmpty_s;
    logic               bufFull_s;
    logic               pushReq_s;
    logic               popReq_s;

    // oReady depends only on buffer occupancy, never on iValid.
    assign oReady    = !bufFull_s;
    assign pushReq_s = iValid && !bufFull_s;
    assign popReq_s  = (state_r == IDLE) && !bufEmpty_s;

    lcd_feeder_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_buf (
        .clk      (clk),
        .iReset_n (iReset_n),
        .push     (pushReq_s),
        .pushData ({iRS, iByte}),
        .pop      (popReq_s),
        .popData  (bufData_s),
        .empty    (bufEmpty_s),
        .full     (bufFull_s)
    );

    assign oLCD_data    = lcdData_r;
    assign oLCD_RS      = lcdRs_r;
    assign oLCD_writeEN = lcdWriteEn_r;
    assign oError       = error_r;
    assign oBusy        = (state_r != IDLE) || !bufEmpty_s;

    // Byte sequencer: pop, high nibble handshake, release, low nibble
    // handshake, settling delay. Controller outputs are set on the transition
    // into each state so they are already valid during that state.
    always_ff @(posedge clk) begin
        if (!iReset_n) begin
            state_r      <= IDLE;
            curByte_r    <= 8'h00;
            curRs_r      <= 1'b0;
            respCnt_r    <= CNT_ZERO;
            delayCnt_r   <= CNT_ZERO;
            lcdData_r    <= 4'h0;
            lcdRs_r      <= 1'b0;
            lcdWriteEn_r <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (popReq_s) begin
                        curByte_r    <= bufData_s[7:0];
                        curRs_r      <= bufData_s[8];
                        lcdData_r    <= bufData_s[7:4];
                        lcdRs_r      <= bufData_s[8];
                        lcdWriteEn_r <= 1'b1;
                        respCnt_r    <= CNT_ZERO;
                        state_r      <= SEND_HI;
                    end else begin
                        lcdWriteEn_r <= 1'b0;
                    end
                end
                SEND_HI: begin
                    // An acknowledge on the final allowed cycle still counts.
                    if (iLCD_response) begin
                        lcdWriteEn_r <= 1'b0;
                        state_r      <= REL_HI;
                    end else if (respCnt_r >= RESP_LAST) begin
                        lcdWriteEn_r <= 1'b0;
                        error_r      <= 1'b1;
                        state_r      <= IDLE;
                    end else begin
                        respCnt_r <= respCnt_r + CNT_ONE;
                    end
                end
                REL_HI: begin
                    lcdData_r    <= curByte_r[3:0];
                    lcdWriteEn_r <= 1'b1;
                    respCnt_r    <= CNT_ZERO;
                    state_r      <= SEND_LO;
                end
                SEND_LO: begin
                    if (iLCD_response) begin
                        lcdWriteEn_r <= 1'b0;
                        delayCnt_r   <= isLongCmd(curRs_r, curByte_r) ? WAIT_LONG_CNT
                                                                      : WAIT_SHORT_CNT;
                        state_r      <= DELAY;
                    end else if (respCnt_r >= RESP_LAST) begin
                        lcdWriteEn_r <= 1'b0;
                        error_r      <= 1'b1;
                        state_r      <= IDLE;
                    end else begin
                        respCnt_r <= respCnt_r + CNT_ONE;
                    end
                end
                DELAY: begin
                    lcdWriteEn_r <= 1'b0;
                    if (delayCnt_r == CNT_ZERO) begin
                        state_r <= IDLE;
                    end else begin
                        delayCnt_r <= delayCnt_r - CNT_ONE;
                    end
                end
                default: begin
                    lcdWriteEn_r <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_byte_feeder.sv
// Scoreboard bench for lcd_byte_feeder. Stimulus pushes the expected nibble
// writes into a queue as each byte is accepted; a monitor pops and checks
// each controller write request (nibble, RS, low gap before it, high length,
// stability). A responder models the controller acknowledge.
module tb_lcd_byte_feeder;

    localparam int WS = 30;
    localparam int WL = 100;
    localparam int RT = 1024;
    // After the low-nibble ack, DELAY spans WAIT+1 cycles and one IDLE cycle
    // pops the next byte, so writeEN is low for WAIT+2 sampled cycles.
    localparam int GAP_SHORT = WS + 2;
    localparam int GAP_LONG  = WL + 2;
    localparam int NO_CHK    = -1;
    localparam int K_NORMAL  = 0;
    localparam int K_TIMEOUT = 1;
    localparam int K_ABORT   = 2;

    logic       clk = 1'b0;
    logic       iReset_n;
    logic [7:0] iByte;
    logic       iRS;
    logic       iValid;
    logic       oReady;
    logic [3:0] oLCD_data;
    logic       oLCD_RS;
    logic       oLCD_writeEN;
    logic       iLCD_response = 1'b0;
    logic       oBusy;
    logic       oError;

    always #5 clk = ~clk;

    lcd_byte_feeder #(
        .WAIT_SHORT   (WS),
        .WAIT_LONG    (WL),
        .RESP_TIMEOUT (RT)
    ) dut (
        .clk           (clk),
        .iReset_n      (iReset_n),
        .iByte         (iByte),
        .iRS           (iRS),
        .iValid        (iValid),
        .oReady        (oReady),
        .oLCD_data     (oLCD_data),
        .oLCD_RS       (oLCD_RS),
        .oLCD_writeEN  (oLCD_writeEN),
        .iLCD_response (iLCD_response),
        .oBusy         (oBusy),
        .oError        (oError)
    );

    typedef struct { int nib; int rs; int gap; int high; } exp_t;
    typedef struct { logic [7:0] b; logic rs; int hi; int lo; int gap; } vec_t;

    exp_t sbQ[$];
    int   nVec      = 0;
    int   nMis      = 0;
    int   riseCount = 0;
    int   ackDelay  = 3;
    bit   ackEn     = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        nVec++;
        if (act != exp) begin
            nMis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Controller model: acknowledge on the ackDelay-th sampled cycle of a request.
    int reqCyc = 0;
    always @(negedge clk) begin
        if (oLCD_writeEN && ackEn) begin
            reqCyc        = reqCyc + 1;
            iLCD_response = (reqCyc == ackDelay);
        end else begin
            reqCyc        = 0;
            iLCD_response = 1'b0;
        end
    end

    // Monitor: one scoreboard entry per write request.
    exp_t       cur;
    bit         curValid = 1'b0;
    int         highRun  = 0;
    int         lowRun   = 0;
    logic [3:0] capData;
    logic       capRs;
    bit         stable;
    bit         prevWe   = 1'b0;
    always @(negedge clk) begin
        if (oLCD_writeEN && !prevWe) begin
            riseCount = riseCount + 1;
            if (sbQ.size() == 0) begin
                chk("unexpected_request", 1, 0);
                curValid = 1'b0;
            end else begin
                cur      = sbQ.pop_front();
                curValid = 1'b1;
                chk("nibble", int'(oLCD_data), cur.nib);
                chk("rs", int'(oLCD_RS), cur.rs);
                if (cur.gap >= 0) chk("gap", lowRun, cur.gap);
            end
            highRun = 1;
            capData = oLCD_data;
            capRs   = oLCD_RS;
            stable  = 1'b1;
        end else if (oLCD_writeEN) begin
            highRun = highRun + 1;
            if (oLCD_data != capData || oLCD_RS != capRs) stable = 1'b0;
        end else if (prevWe) begin
            if (curValid) begin
                if (cur.high >= 0) chk("high_len", highRun, cur.high);
                chk("stable", int'(stable), 1);
                curValid = 1'b0;
            end
            lowRun = 1;
        end else begin
            lowRun = lowRun + 1;
        end
        prevWe = oLCD_writeEN;
    end

    task automatic pushByte(input logic [7:0] b, input logic rs, input int hiNib,
                            input int loNib, input int gap, input int kind);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (!oReady && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", int'(oReady), 1);
        iByte  = b;
        iRS    = rs;
        iValid = 1'b1;
        @(posedge clk);
        #1 iValid = 1'b0;
        e.nib  = hiNib;
        e.rs   = int'(rs);
        e.gap  = gap;
        e.high = (kind == K_TIMEOUT) ? RT : ackDelay;
        sbQ.push_back(e);
        if (kind != K_TIMEOUT) begin
            e.nib  = loNib;
            e.gap  = 1;
            e.high = (kind == K_ABORT) ? NO_CHK : ackDelay;
            sbQ.push_back(e);
        end
    endtask

    task automatic waitIdle(input int limit);
        int n = 0;
        @(negedge clk);
        while ((oBusy || sbQ.size() != 0 || curValid) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("reach_idle", int'(n < limit), 1);
    endtask

    vec_t vecB [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", nVec);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int n;
        vecB[0] = '{8'h01, 1'b0, 0,  1,  NO_CHK};
        vecB[1] = '{8'h30, 1'b1, 3,  0,  GAP_LONG};
        vecB[2] = '{8'h02, 1'b0, 0,  2,  GAP_SHORT};
        vecB[3] = '{8'h02, 1'b1, 0,  2,  GAP_LONG};
        vecB[4] = '{8'h01, 1'b1, 0,  1,  GAP_SHORT};
        vecB[5] = '{8'h7E, 1'b0, 7,  14, GAP_SHORT};
        vecB[6] = '{8'h03, 1'b0, 0,  3,  GAP_SHORT};
        vecB[7] = '{8'hA5, 1'b1, 10, 5,  GAP_SHORT};

        iReset_n = 1'b0;
        iValid   = 1'b0;
        iByte    = 8'h00;
        iRS      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_writeEN", int'(oLCD_writeEN), 0);
        chk("rst_data", int'(oLCD_data), 0);
        chk("rst_rs", int'(oLCD_RS), 0);
        chk("rst_error", int'(oError), 0);
        chk("rst_busy", int'(oBusy), 0);
        chk("rst_ready", int'(oReady), 1);
        iReset_n = 1'b1;

        // Data byte 'A' then 'B': second byte waits out the short delay.
        pushByte(8'h41, 1'b1, 4, 1, NO_CHK, K_NORMAL);
        pushByte(8'h42, 1'b1, 4, 2, GAP_SHORT, K_NORMAL);
`ifndef LCD_FEEDER_FIFO_EN
        @(negedge clk);
        chk("holding_full_ready", int'(oReady), 0);
`endif
        waitIdle(2000);

        // Long vs short delay selection, including data bytes 0x01/0x02.
        for (int i = 0; i < 8; i++) begin
            pushByte(vecB[i].b, vecB[i].rs, vecB[i].hi, vecB[i].lo, vecB[i].gap, K_NORMAL);
        end
        waitIdle(3000);

        // Controller never acknowledges: timeout, abandon byte, sticky error.
        ackEn = 1'b0;
        pushByte(8'h5A, 1'b1, 5, 10, NO_CHK, K_TIMEOUT);
        waitIdle(RT + 200);
        chk("timeout_error", int'(oError), 1);
        chk("timeout_idle", int'(oBusy), 0);
        ackEn = 1'b1;
        pushByte(8'h33, 1'b1, 3, 3, NO_CHK, K_NORMAL);
        waitIdle(2000);
        chk("error_sticky", int'(oError), 1);

        // Reset while the low nibble is being offered.
        base = riseCount;
        pushByte(8'h9C, 1'b0, 9, 12, NO_CHK, K_ABORT);
        n = 0;
        while (riseCount < base + 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reach_send_lo", int'(riseCount >= base + 2), 1);
        iReset_n = 1'b0;
        @(negedge clk);
        chk("midrst_writeEN", int'(oLCD_writeEN), 0);
        chk("midrst_busy", int'(oBusy), 0);
        chk("midrst_error", int'(oError), 0);
        chk("midrst_ready", int'(oReady), 1);
        iReset_n = 1'b1;
        pushByte(8'h21, 1'b1, 2, 1, NO_CHK, K_NORMAL);
        waitIdle(2000);

`ifdef LCD_FEEDER_FIFO_EN
        // Slow controller: one byte in flight plus four buffered fills the FIFO.
        ackDelay = 40;
        pushByte(8'h11, 1'b1, 1, 1, NO_CHK, K_NORMAL);
        pushByte(8'h22, 1'b1, 2, 2, GAP_SHORT, K_NORMAL);
        pushByte(8'h01, 1'b0, 0, 1, GAP_SHORT, K_NORMAL);
        pushByte(8'h44, 1'b1, 4, 4, GAP_LONG, K_NORMAL);
        pushByte(8'h55, 1'b1, 5, 5, GAP_SHORT, K_NORMAL);
        @(negedge clk);
        chk("fifo_full_ready", int'(oReady), 0);
        pushByte(8'h66, 1'b1, 6, 6, GAP_SHORT, K_NORMAL);
        waitIdle(5000);
        ackDelay = 3;
`endif

        chk("scoreboard_empty", sbQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
